// File: rtl/high_score_keeper_pkg.sv
// Shared definitions for the high-score bank: FSM encoding, BCD limits, score width.
package high_score_keeper_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_COMPARE = 2'd2,
    S_WRITE   = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int         SCORE_W = 8;

  // Clamp an out-of-range BCD digit (A..F) to 9.
  function automatic logic [3:0] sat_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/high_score_keeper_bcd2_compare.sv
// Two-digit BCD magnitude compare; score words are packed {tens, ones}.
import high_score_keeper_pkg::*;

module bcd2_compare (
  input  logic [SCORE_W-1:0] a,
  input  logic [SCORE_W-1:0] b,
  output logic               gt,
  output logic               eq
);

  logic [3:0] a_tens, a_ones, b_tens, b_ones;

  // Tens digit decides unless equal, then ones digit.
  always_comb begin
    a_tens = a[7:4];
    a_ones = a[3:0];
    b_tens = b[7:4];
    b_ones = b[3:0];
    gt     = (a_tens > b_tens) || ((a_tens == b_tens) && (a_ones > b_ones));
    eq     = (a_tens == b_tens) && (a_ones == b_ones);
  end

endmodule

// File: rtl/high_score_keeper.sv
// Per-player best-score bank with overall champion tracking.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for an eligible game_over; captures id and raw score
// S_CAPTURE | saturates captured digits, reads the player's stored best
// S_COMPARE | new score vs stored best; only strictly higher proceeds
// S_WRITE   | stores score, pulses new_record, updates champion if beaten
import high_score_keeper_pkg::*;

module high_score_keeper #(
  parameter int NUM_PLAYERS = 8,
  parameter int ID_W        = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            logged_in,
  input  logic [ID_W-1:0] player_id,
  input  logic            is_guest,
  input  logic            game_over,
  input  logic [3:0]      score_tens,
  input  logic [3:0]      score_ones,
  output logic [3:0]      best_tens,
  output logic [3:0]      best_ones,
  output logic [3:0]      champ_tens,
  output logic [3:0]      champ_ones,
  output logic [ID_W-1:0] champ_id,
  output logic            champ_valid,
  output logic            new_record,
  output logic            busy
);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      cap_id_q, cap_id_d;
  logic [3:0]           cap_tens_q, cap_tens_d;
  logic [3:0]           cap_ones_q, cap_ones_d;
  logic [SCORE_W-1:0]   slot_rd_q, slot_rd_d;
  logic [SCORE_W-1:0]   slot_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]   slot_d [NUM_PLAYERS];
  logic [SCORE_W-1:0]   champ_q, champ_d;
  logic [ID_W-1:0]      champ_id_q, champ_id_d;
  logic                 champ_valid_q, champ_valid_d;
  logic                 new_record_q, new_record_d;
  logic [SCORE_W-1:0]   best_q, best_d;

  logic [SCORE_W-1:0]   cap_score;
  logic                 start_ok;
  logic                 cap_id_ok;
  logic                 live_id_ok;
  logic                 slot_gt, slot_eq;
  logic                 champ_gt, champ_eq;

  assign cap_score  = {cap_tens_q, cap_ones_q};
  assign start_ok   = game_over && logged_in && !is_guest;
  assign cap_id_ok  = int'(cap_id_q) < NUM_PLAYERS;
  assign live_id_ok = int'(player_id) < NUM_PLAYERS;

  bcd2_compare u_slot_cmp (
    .a  (cap_score),
    .b  (slot_rd_q),
    .gt (slot_gt),
    .eq (slot_eq)
  );

  bcd2_compare u_champ_cmp (
    .a  (cap_score),
    .b  (champ_q),
    .gt (champ_gt),
    .eq (champ_eq)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers: captured game, slot bank, champion, display read.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_id_q      <= '0;
      cap_tens_q    <= '0;
      cap_ones_q    <= '0;
      slot_rd_q     <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) slot_q[i] <= '0;
      champ_q       <= '0;
      champ_id_q    <= '0;
      champ_valid_q <= 1'b0;
      new_record_q  <= 1'b0;
      best_q        <= '0;
    end else begin
      cap_id_q      <= cap_id_d;
      cap_tens_q    <= cap_tens_d;
      cap_ones_q    <= cap_ones_d;
      slot_rd_q     <= slot_rd_d;
      for (int i = 0; i < NUM_PLAYERS; i++) slot_q[i] <= slot_d[i];
      champ_q       <= champ_d;
      champ_id_q    <= champ_id_d;
      champ_valid_q <= champ_valid_d;
      new_record_q  <= new_record_d;
      best_q        <= best_d;
    end
  end

  // Next-state and datapath updates; everything holds unless a state acts on it.
  always_comb begin
    state_d       = state_q;
    cap_id_d      = cap_id_q;
    cap_tens_d    = cap_tens_q;
    cap_ones_d    = cap_ones_q;
    slot_rd_d     = slot_rd_q;
    for (int i = 0; i < NUM_PLAYERS; i++) slot_d[i] = slot_q[i];
    champ_d       = champ_q;
    champ_id_d    = champ_id_q;
    champ_valid_d = champ_valid_q;
    new_record_d  = 1'b0;

    // Display follows the live login, not the captured one.
    best_d = (logged_in && !is_guest && live_id_ok) ? slot_q[player_id] : '0;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          cap_id_d   = player_id;
          cap_tens_d = score_tens;
          cap_ones_d = score_ones;
          state_d    = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        cap_tens_d = sat_bcd(cap_tens_q);
        cap_ones_d = sat_bcd(cap_ones_q);
        slot_rd_d  = cap_id_ok ? slot_q[cap_id_q] : '0;
        state_d    = S_COMPARE;
      end
      S_COMPARE: begin
        state_d = (slot_gt && !slot_eq) ? S_WRITE : S_IDLE;
      end
      S_WRITE: begin
        if (cap_id_ok) slot_d[cap_id_q] = cap_score;
        new_record_d = 1'b1;
        // A tie leaves the earlier champion in place.
        if (champ_gt && !champ_eq) begin
          champ_d       = cap_score;
          champ_id_d    = cap_id_q;
          champ_valid_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign best_tens   = best_q[7:4];
  assign best_ones   = best_q[3:0];
  assign champ_tens  = champ_q[7:4];
  assign champ_ones  = champ_q[3:0];
  assign champ_id    = champ_id_q;
  assign champ_valid = champ_valid_q;
  assign new_record  = new_record_q;
  assign busy        = (state_q != S_IDLE);

endmodule
